spike_scheduler: RTL and testbench
==================================

# spike_scheduler

Round-robin scheduler sharing one indexed spike-pulse output between several spike sources (layer neurons / input encoders) in the ODESA digit-recognition SNN. Each source posts a spike as a non-zero index. The block latches the spike as pending and grants sources in rotating order. Each granted spike is emitted as a single-cycle index pulse on a shared bus, followed by a programmable quiet gap, so downstream synapse logic sees at most one spike per slot.

## Interface
Parameters:
- P_REQ, 4: number of requesters (2..16).
- P_N, 5: index width; index 0 means "no spike".
- P_GAP, 1: zero-output cycles after each pulse (0..7).

Ports:
- i_clk  in  1  single clock; all logic on rising edge.
- i_rst  in  1  reset, synchronous, active-high.
- i_req  in  P_REQ  per-requester spike strobe, sampled every edge.
- i_index  in  P_REQ*P_N  packed indices; requester k uses bits [k*P_N +: P_N].
- o_spike  out  P_N  emitted index during the FIRE cycle, else 0.
- o_valid  out  1  high exactly in the FIRE cycle.
- o_ack  out  P_REQ  one-hot, high in the FIRE cycle for the served requester.
- o_drop  out  P_REQ  one-cycle pulse when a request is lost because that requester is already pending.
- o_busy  out  1  high when any pending bit is set or the FSM is not in IDLE.
- o_spike_cnt  out  16  emitted-spike count (statistics option).
- o_drop_cnt  out  16  dropped-request count (statistics option).

## Operation
- Capture stage: per requester, a pending bit r_pend[k] and an index register r_idx[k].
  - On an edge with i_req[k]=1, index non-zero and r_pend[k]=0: set r_pend[k] and store the index.
  - If index is 0: ignore; no pending bit, no drop.
  - If i_req[k]=1, index non-zero and r_pend[k]=1 with no clear on that edge: o_drop[k]=1 next cycle; stored index unchanged.
- FSM states:
  - IDLE: if any r_pend is set, pick a winner by round-robin from r_ptr upward, modulo P_REQ. Load r_out from the winner's r_idx, clear the winner's r_pend, set r_ptr to winner+1 mod P_REQ, go to FIRE. Otherwise stay in IDLE.
  - FIRE: o_spike=r_out, o_valid=1, o_ack[winner]=1. Next state is GAP if P_GAP>0, else IDLE.
  - GAP: o_spike=0. A 3-bit counter runs P_GAP cycles, then returns to IDLE. Capture continues during GAP.
- Clear and set on the same edge for the same requester: set wins. The new index is stored, pending stays 1, no drop.
- Reset values: all outputs 0, r_pend=0, r_idx=0, r_out=0, r_ptr=0, FSM=IDLE, gap counter 0, statistics counters 0.
- Reset mid-operation: next edge forces the reset state. In-flight and pending spikes are discarded, with no o_ack.

## Timing
- Request sampled at edge k.
- From IDLE with no other pending: winner selected at edge k+1, FIRE cycle lies between edges k+1 and k+2.
- Spike latency is 1 cycle after capture.
- Slot period is 1 (IDLE) + 1 (FIRE) + P_GAP cycles.
- Sustained throughput is one spike per 2+P_GAP cycles.
- o_spike, o_valid, o_ack and o_drop are registered or decoded from registered state only. There is no combinational path from i_* to outputs.
- Fairness: with all requesters continuously pending, each is served once per P_REQ slots.

## Configuration
- Macro SPIKE_SCHED_STATS_EN.
- Defined:
  - o_spike_cnt increments on each FIRE cycle.
  - o_drop_cnt increments by 1 per cycle in which any o_drop bit is set, however many bits are set.
  - Both saturate at 16'hFFFF and clear on i_rst.
- Undefined: both outputs tied to 0 and no counter logic is synthesised. All other behaviour is identical.

## Test plan
- Reset: i_rst high 2 cycles with i_req all 1 -> all outputs 0 throughout, no o_valid; first FIRE occurs 2 cycles after i_rst falls.
- Single spike: P_GAP=1, requester 2 strobes index 5'd9 once at edge k -> o_spike=9, o_valid=1, o_ack=4'b0100 in cycle k+1..k+2 only, o_busy falls after GAP.
- Round-robin: all four requesters post indices 1,2,3,4 on the same edge -> emitted order 1,2,3,4 with 2 zero cycles between pulses (P_GAP=1). Repeat with r_ptr=2 -> order 3,4,1,2.
- Zero index and drop: requester 0 strobes index 0 -> no pending, no drop. Requester 1 strobes 7, then 8 while still pending -> o_drop[1] pulses once, 7 is emitted, 8 is lost; o_drop_cnt=1 when SPIKE_SCHED_STATS_EN is defined.
- Set-clear collision: requester 3 re-strobes index 12 on its grant edge -> first index is emitted, then 12 in the next slot, no drop.
- Mid-operation reset: i_rst asserted during FIRE with 3 pending -> next cycle all outputs 0, pending cleared, no further o_ack.

Source files
------------

// File: rtl/spike_scheduler.sv
// spike_scheduler: round-robin arbiter that serialises indexed spikes onto one pulse bus.
// Optional statistics counters are enabled by defining SPIKE_SCHED_STATS_EN.
module spike_scheduler #(
    parameter int P_REQ = 4,
    parameter int P_N   = 5,
    parameter int P_GAP = 1
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic [P_REQ-1:0]       i_req,
    input  logic [P_REQ*P_N-1:0]   i_index,
    output logic [P_N-1:0]         o_spike,
    output logic                   o_valid,
    output logic [P_REQ-1:0]       o_ack,
    output logic [P_REQ-1:0]       o_drop,
    output logic                   o_busy,
    output logic [15:0]            o_spike_cnt,
    output logic [15:0]            o_drop_cnt
);
    localparam int            PW       = (P_REQ > 1) ? $clog2(P_REQ) : 1;
    localparam logic [PW:0]   REQ_L    = P_REQ[PW:0];
    localparam logic [2:0]    GAP_LAST = (P_GAP > 0) ? 3'(P_GAP - 1) : 3'd0;

    typedef enum logic [1:0] {S_IDLE, S_FIRE, S_GAP} state_t;

    state_t           r_state, w_state_nxt;
    logic [P_REQ-1:0] r_pend, r_drop, w_set, w_clr;
    logic [P_N-1:0]   r_idx [P_REQ];
    logic [P_N-1:0]   w_idx [P_REQ];
    logic [P_N-1:0]   r_out;
    logic [PW-1:0]    r_ptr, r_win, w_win, w_ptr_nxt;
    logic [PW:0]      w_sum, w_inc;
    logic             w_any;
    logic [2:0]       r_gap;

    // Scan downward so the pending requester closest to r_ptr is the last one kept
    always_comb begin
        w_any = 1'b0;
        w_win = '0;
        w_sum = '0;
        for (int i = P_REQ - 1; i >= 0; i--) begin
            w_sum = {1'b0, r_ptr} + i[PW:0];
            if (w_sum >= REQ_L) w_sum = w_sum - REQ_L;
            if (r_pend[w_sum[PW-1:0]]) begin
                w_any = 1'b1;
                w_win = w_sum[PW-1:0];
            end
        end
        w_inc     = {1'b0, w_win} + {{PW{1'b0}}, 1'b1};
        w_ptr_nxt = (w_inc == REQ_L) ? '0 : w_inc[PW-1:0];
    end

    always_comb begin
        for (int k = 0; k < P_REQ; k++) begin
            w_idx[k] = i_index[k*P_N +: P_N];
            w_set[k] = i_req[k] && (w_idx[k] != '0);
            w_clr[k] = (r_state == S_IDLE) && w_any && (w_win == k[PW-1:0]);
        end
    end

    // Capture: a new strobe on the grant edge re-arms the slot instead of dropping
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_pend <= '0;
            r_drop <= '0;
            for (int k = 0; k < P_REQ; k++) r_idx[k] <= '0;
        end else begin
            for (int k = 0; k < P_REQ; k++) begin
                if (w_set[k] && (!r_pend[k] || w_clr[k])) begin
                    r_pend[k] <= 1'b1;
                    r_idx[k]  <= w_idx[k];
                end else if (w_clr[k]) begin
                    r_pend[k] <= 1'b0;
                end
                r_drop[k] <= w_set[k] && r_pend[k] && !w_clr[k];
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
            r_out   <= '0;
            r_win   <= '0;
            r_ptr   <= '0;
            r_gap   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == S_IDLE && w_any) begin
                r_out <= r_idx[w_win];
                r_win <= w_win;
                r_ptr <= w_ptr_nxt;
            end
            r_gap <= (r_state == S_GAP) ? r_gap + 3'd1 : 3'd0;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_any) w_state_nxt = S_FIRE;
            S_FIRE:  w_state_nxt = (P_GAP > 0) ? S_GAP : S_IDLE;
            S_GAP:   if (r_gap == GAP_LAST) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        o_spike = '0;
        o_valid = 1'b0;
        o_ack   = '0;
        if (r_state == S_FIRE) begin
            o_spike = r_out;
            o_valid = 1'b1;
            for (int k = 0; k < P_REQ; k++) o_ack[k] = (r_win == k[PW-1:0]);
        end
        o_drop = r_drop;
        o_busy = (|r_pend) || (r_state != S_IDLE);
    end

`ifdef SPIKE_SCHED_STATS_EN
    logic [15:0] r_spike_cnt, r_drop_cnt;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_spike_cnt <= '0;
            r_drop_cnt  <= '0;
        end else begin
            if (r_state == S_FIRE) r_spike_cnt <= sat_inc(r_spike_cnt);
            if (|r_drop)           r_drop_cnt  <= sat_inc(r_drop_cnt);
        end
    end

    assign o_spike_cnt = r_spike_cnt;
    assign o_drop_cnt  = r_drop_cnt;
`else
    assign o_spike_cnt = '0;
    assign o_drop_cnt  = '0;
`endif

endmodule

// File: tb/tb_spike_scheduler.sv
// Randomised scoreboard bench for spike_scheduler against a slot-level reference model.
module tb_spike_scheduler;
    localparam int NR = 4;
    localparam int NB = 5;
    localparam int NG = 1;

    logic            i_clk = 1'b0;
    logic            i_rst;
    logic [NR-1:0]   i_req;
    logic [NR*NB-1:0] i_index;
    logic [NB-1:0]   o_spike;
    logic            o_valid;
    logic [NR-1:0]   o_ack, o_drop;
    logic            o_busy;
    logic [15:0]     o_spike_cnt, o_drop_cnt;

    spike_scheduler #(.P_REQ(NR), .P_N(NB), .P_GAP(NG)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_req(i_req), .i_index(i_index),
        .o_spike(o_spike), .o_valid(o_valid), .o_ack(o_ack), .o_drop(o_drop),
        .o_busy(o_busy), .o_spike_cnt(o_spike_cnt), .o_drop_cnt(o_drop_cnt)
    );

    always #5 i_clk = ~i_clk;

    typedef struct { bit v; bit [NR-1:0] drop; bit busy; } cyc_t;
    typedef struct { int spike; int who; } fire_t;

    cyc_t  cq[$];
    fire_t fq[$];
    int    n_checks = 0;
    int    n_errors = 0;

    // Reference state: what is waiting, whose turn it is, and how long until the next slot opens
    bit m_pend[NR];
    int m_idx[NR];
    int m_ptr, m_wait, m_scnt, m_dcnt;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_edge(input bit rst, input logic [NR-1:0] req, input logic [NR*NB-1:0] idx);
        cyc_t  c;
        fire_t f;
        bit    old_pend[NR];
        bit    clr[NR];
        bit    set;
        int    w, v;
        c.v = 0; c.drop = '0; c.busy = 0;
        if (rst) begin
            for (int k = 0; k < NR; k++) begin m_pend[k] = 0; m_idx[k] = 0; end
            m_ptr = 0; m_wait = 0; m_scnt = 0; m_dcnt = 0;
            cq.push_back(c);
            return;
        end
        for (int k = 0; k < NR; k++) begin old_pend[k] = m_pend[k]; clr[k] = 0; end
        w = -1;
        if (m_wait == 0) begin
            for (int i = 0; i < NR; i++)
                if (w < 0 && m_pend[(m_ptr + i) % NR]) w = (m_ptr + i) % NR;
            if (w >= 0) begin
                f.spike = m_idx[w];
                f.who   = w;
                fq.push_back(f);
                clr[w]  = 1;
                m_ptr   = (w + 1) % NR;
                m_wait  = 1 + NG;
                c.v     = 1;
                if (m_scnt < 65535) m_scnt++;
            end
        end else begin
            m_wait--;
        end
        for (int k = 0; k < NR; k++) begin
            v   = int'(idx[k*NB +: NB]);
            set = req[k] && (v != 0);
            if (set && (!old_pend[k] || clr[k])) begin
                m_pend[k] = 1;
                m_idx[k]  = v;
            end else if (clr[k]) begin
                m_pend[k] = 0;
            end
            c.drop[k] = set && old_pend[k] && !clr[k];
        end
        if (c.drop != '0 && m_dcnt < 65535) m_dcnt++;
        c.busy = (m_wait > 0);
        for (int k = 0; k < NR; k++) if (m_pend[k]) c.busy = 1;
        cq.push_back(c);
    endtask

    task automatic cyc(input bit rst, input logic [NR-1:0] req, input logic [NR*NB-1:0] idx);
        i_rst = rst; i_req = req; i_index = idx;
        @(posedge i_clk);
        model_edge(rst, req, idx);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, '0, '0);
    endtask

    function automatic logic [NR*NB-1:0] pk(input int a, input int b, input int c, input int d);
        return {5'(d), 5'(c), 5'(b), 5'(a)};
    endfunction

    always @(negedge i_clk) begin
        cyc_t  c;
        fire_t f;
        if (cq.size() > 0) begin
            c = cq.pop_front();
            chk("valid", int'(o_valid), int'(c.v));
            chk("drop", int'(o_drop), int'(c.drop));
            chk("busy", int'(o_busy), int'(c.busy));
            if (o_valid) begin
                if (fq.size() == 0) begin
                    chk("fire_unexpected", 1, 0);
                end else begin
                    f = fq.pop_front();
                    chk("spike", int'(o_spike), f.spike);
                    chk("ack", int'(o_ack), 1 << f.who);
                end
            end else begin
                chk("quiet_spike", int'(o_spike), 0);
                chk("quiet_ack", int'(o_ack), 0);
            end
        end
    end

    task automatic chk_stats(input string tag);
`ifdef SPIKE_SCHED_STATS_EN
        chk({tag, "_spike_cnt"}, int'(o_spike_cnt), m_scnt);
        chk({tag, "_drop_cnt"}, int'(o_drop_cnt), m_dcnt);
`else
        chk({tag, "_spike_cnt"}, int'(o_spike_cnt), 0);
        chk({tag, "_drop_cnt"}, int'(o_drop_cnt), 0);
`endif
    endtask

    initial begin
        logic [NR-1:0]    rq;
        logic [NR*NB-1:0] ix;
        // Reset held with all requesters strobing; one strobe survives the release
        cyc(1'b1, 4'hF, pk(1, 2, 3, 4));
        cyc(1'b1, 4'hF, pk(1, 2, 3, 4));
        chk_stats("reset");
        cyc(1'b0, 4'hF, pk(1, 2, 3, 4));
        idle(14);
        // Single spike from requester 2
        cyc(1'b0, 4'b0100, pk(0, 0, 9, 0));
        idle(5);
        // Four simultaneous posts, then again with the pointer moved to 2
        cyc(1'b0, 4'hF, pk(1, 2, 3, 4));
        idle(13);
        cyc(1'b0, 4'b0001, pk(5, 0, 0, 0));
        idle(3);
        cyc(1'b0, 4'b0010, pk(0, 6, 0, 0));
        idle(3);
        cyc(1'b0, 4'hF, pk(1, 2, 3, 4));
        idle(13);
        // Zero index is ignored; second strobe while pending is dropped
        cyc(1'b0, 4'b0001, pk(0, 0, 0, 0));
        idle(2);
        cyc(1'b0, 4'b0001, pk(3, 0, 0, 0));
        cyc(1'b0, 4'b0010, pk(0, 7, 0, 0));
        cyc(1'b0, 4'b0010, pk(0, 8, 0, 0));
        idle(8);
        // Re-strobe on the grant edge
        cyc(1'b0, 4'b1000, pk(0, 0, 0, 5));
        cyc(1'b0, 4'b1000, pk(0, 0, 0, 12));
        idle(8);
        chk_stats("directed");
        // Reset during FIRE with three still pending
        cyc(1'b0, 4'hF, pk(11, 12, 13, 14));
        cyc(1'b0, '0, '0);
        cyc(1'b1, '0, '0);
        idle(6);
        chk_stats("midreset");
        // Random traffic with occasional resets
        for (int n = 0; n < 600; n++) begin
            for (int k = 0; k < NR; k++) begin
                rq[k] = ($urandom_range(0, 99) < 25);
                ix[k*NB +: NB] = 5'($urandom_range(0, 31));
            end
            cyc(($urandom_range(0, 149) == 0), rq, ix);
        end
        idle(20);
        chk_stats("final");
        chk("fire_q_empty", fq.size(), 0);
        @(negedge i_clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
